fx2_fifo_arbiter: RTL and testbench
===================================

FX2_FIFO_ARBITER -- requirements
Module: fx2_fifo_arbiter

Interface
REQ-001 Parameter TX_BURST, default 32, is the maximum number of I/Q pairs written to EP6 per TX grant.
REQ-002 Parameter RX_BURST, default 8, is the maximum number of words read from EP2 per RX grant.
REQ-003 Ports (name, direction, width, meaning), clock and reset first:
- IFCLK  in  1  sole clock, FX2 interface clock.
- reset  in  1  synchronous, active-high.
- tx_iword  in  16  I word of head pair, show-ahead source FIFO.
- tx_qword  in  16  Q word of head pair.
- tx_empty  in  1  source I/Q FIFO empty.
- tx_rdreq  out  1  one-cycle pulse that pops one I/Q pair.
- rx_data  out  16  word read from EP2.
- rx_valid  out  1  one-cycle strobe qualifying rx_data.
- rx_full  in  1  downstream cannot accept RX words.
- FLAGA  in  1  EP2 not-empty (low = empty), fixed-flag mode, valid for any FIFO_ADR.
- FLAGB  in  1  EP6 not-full (low = full), fixed-flag mode.
- FD_in  in  16  FX2 data bus input.
- FD_out  out  16  FX2 data bus output.
- FD_oe  out  1  FD output enable; high only while writing.
- SLWR  out  1  FX2 write strobe, active low.
- SLRD  out  1  FX2 read strobe, active low.
- SLOE  out  1  FX2 output enable, active low.
- FIFO_ADR  out  2  endpoint select: 2'b10 = EP6, 2'b00 = EP2.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 States SHALL be IDLE, TX_ADDR, TX_I, TX_Q, RX_ADDR, RX_READ, RX_TURN.
REQ-006 tx_req = FLAGB & ~tx_empty and rx_req = FLAGA & ~rx_full, both evaluated in IDLE.
REQ-007 IDLE arbitration SHALL be round-robin.
- Both requesting: grant the side not granted last.
- One requesting: grant that side.
- Neither requesting: stay in IDLE.
REQ-008 TX_ADDR SHALL last exactly one cycle, with FIFO_ADR=2'b10, FD_oe=1 and SLWR=1, then go to TX_I.
REQ-009 In TX_I, if FLAGB=1, tx_empty=0 and pair count < TX_BURST:
- next cycle drives FD_out=tx_iword with SLWR=0;
- state moves to TX_Q.
Otherwise the block releases the grant: FD_oe=0 and state returns to IDLE.
REQ-010 TX_Q SHALL unconditionally drive FD_out=tx_qword with SLWR=0, pulse tx_rdreq, increment the pair count and return to TX_I.
- An I word is always followed by its Q word; no partial pair except on reset.
REQ-011 RX_ADDR SHALL last one cycle with FIFO_ADR=2'b00, FD_oe=0 and SLOE=0.
REQ-012 In RX_READ, if FLAGA=1, rx_full=0 and word count < RX_BURST:
- SLRD=0 for one cycle;
- rx_data takes FD_in on that same edge;
- rx_valid=1 for that cycle.
Otherwise the block goes to RX_TURN.
REQ-013 RX_TURN SHALL drive SLOE=1 for one cycle, then go to IDLE.
- FD_oe=1 and SLOE=0 SHALL never coincide.
REQ-014 Burst counters SHALL clear on each grant and never wrap within a grant.

Reset
REQ-015 Synchronous reset SHALL return the block to its reset values on the next IFCLK edge, from any state:
- state=IDLE, round-robin pointer = RX-last (TX first);
- SLWR=SLRD=SLOE=1, FIFO_ADR=2'b10, FD_out=0, FD_oe=0;
- tx_rdreq=0, rx_valid=0, rx_data=0;
- counters=0.
REQ-016 Reset during TX_Q SHALL abandon the pair without pulsing tx_rdreq, so the pair is re-sent later.

Configuration
REQ-017 Macro FRAME_SYNC_EN defined: TX_ADDR SHALL be followed by states TX_SYNC (FD_out=16'h7F7F, SLWR=0) and TX_SEQ (FD_out=16-bit sequence count, SLWR=0), each one cycle, before TX_I.
- The sequence count resets to 0, increments after each TX_SEQ, and wraps 16'hFFFF to 16'h0000.
- The header SHALL be written only if FLAGB=1 on entry to TX_SYNC; otherwise the grant is released.
REQ-018 FRAME_SYNC_EN undefined: no header states or sequence counter; TX_ADDR goes directly to TX_I.

Verification
REQ-019 Reset; tx_empty=0, FLAGB=1, FLAGA=0 -> FIFO_ADR=10, one settle cycle, 64 SLWR-low cycles alternating I/Q, 32 tx_rdreq pulses, then IDLE.
REQ-020 FLAGA=1, rx_full=0, FD_in=0x0001..0x0008, tx_empty=1 -> SLOE low, 8 SLRD pulses, rx_data 0x0001..0x0008 each with rx_valid, then SLOE high one cycle.
REQ-021 Both sides requesting continuously -> grants TX,RX,TX,RX; FD_oe&~SLOE never true.
REQ-022 FLAGB falls after the 5th pair -> exactly 5 pairs (10 SLWR pulses), 5 tx_rdreq pulses, return to IDLE.
REQ-023 reset asserted in TX_Q -> next cycle all outputs at reset values; no tx_rdreq pulse; same pair re-sent at next grant.
REQ-024 FRAME_SYNC_EN, two TX grants -> first words 7F7F,0000 then 7F7F,0001; without the macro the first word is tx_iword.

Source files
------------

// File: rtl/fx2_fifo_arbiter.sv
// Round-robin arbiter sharing the FX2 slave FIFO bus between an I/Q TX stream (EP6) and RX reads (EP2).
// Optional TX frame header (sync word + sequence count) is enabled by defining FRAME_SYNC_EN.
module fx2_fifo_arbiter #(
    parameter int TX_BURST = 32,
    parameter int RX_BURST = 8
) (
    input  logic        IFCLK,
    input  logic        reset,
    input  logic [15:0] tx_iword,
    input  logic [15:0] tx_qword,
    input  logic        tx_empty,
    output logic        tx_rdreq,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_full,
    input  logic        FLAGA,
    input  logic        FLAGB,
    input  logic [15:0] FD_in,
    output logic [15:0] FD_out,
    output logic        FD_oe,
    output logic        SLWR,
    output logic        SLRD,
    output logic        SLOE,
    output logic [1:0]  FIFO_ADR
);

    localparam int TXC_W = $clog2(TX_BURST + 1);
    localparam int RXC_W = $clog2(RX_BURST + 1);
    localparam logic [TXC_W-1:0] TX_MAX = TXC_W'(TX_BURST);
    localparam logic [RXC_W-1:0] RX_MAX = RXC_W'(RX_BURST);

    typedef enum logic [3:0] {
        IDLE,
        TX_ADDR,
`ifdef FRAME_SYNC_EN
        TX_SYNC,
        TX_SEQ,
`endif
        TX_I,
        TX_Q,
        RX_ADDR,
        RX_READ,
        RX_TURN
    } state_t;

    state_t            state_q, state_d;
    logic              last_rx_q, last_rx_d;
    logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [RXC_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [15:0]       fd_out_q, fd_out_d;
    logic              fd_oe_q, fd_oe_d;
    logic              slwr_q, slwr_d;
    logic              slrd_q, slrd_d;
    logic              sloe_q, sloe_d;
    logic [1:0]        fifo_adr_q, fifo_adr_d;
    logic              tx_rdreq_q, tx_rdreq_d;
    logic [15:0]       rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
`ifdef FRAME_SYNC_EN
    logic [15:0]       seq_q, seq_d;
`endif

    logic tx_req, rx_req, grant_tx, grant_rx;

    always_comb begin
        tx_req   = FLAGB & ~tx_empty;
        rx_req   = FLAGA & ~rx_full;
        grant_tx = tx_req & (~rx_req | last_rx_q);
        grant_rx = rx_req & ~grant_tx;
    end

    always_comb begin
        state_d    = state_q;
        last_rx_d  = last_rx_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        fd_out_d   = fd_out_q;
        fd_oe_d    = fd_oe_q;
        slwr_d     = 1'b1;
        slrd_d     = 1'b1;
        sloe_d     = sloe_q;
        fifo_adr_d = fifo_adr_q;
        tx_rdreq_d = 1'b0;
        // A word is on FD_in whenever SLRD was low during the cycle just ending.
        rx_data_d  = slrd_q ? rx_data_q : FD_in;
        rx_valid_d = ~slrd_q;
`ifdef FRAME_SYNC_EN
        seq_d      = seq_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_tx) begin
                    state_d    = TX_ADDR;
                    fifo_adr_d = 2'b10;
                    fd_oe_d    = 1'b1;
                    last_rx_d  = 1'b0;
                    tx_cnt_d   = '0;
                end else if (grant_rx) begin
                    state_d    = RX_ADDR;
                    fifo_adr_d = 2'b00;
                    fd_oe_d    = 1'b0;
                    sloe_d     = 1'b0;
                    last_rx_d  = 1'b1;
                    rx_cnt_d   = '0;
                end
            end
            TX_ADDR: begin
`ifdef FRAME_SYNC_EN
                if (FLAGB) begin
                    state_d  = TX_SYNC;
                    fd_out_d = 16'h7F7F;
                    slwr_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                    fd_oe_d = 1'b0;
                end
`else
                state_d = TX_I;
`endif
            end
`ifdef FRAME_SYNC_EN
            TX_SYNC: begin
                state_d  = TX_SEQ;
                fd_out_d = seq_q;
                slwr_d   = 1'b0;
            end
            TX_SEQ: begin
                state_d = TX_I;
                seq_d   = seq_q + 16'd1;
            end
`endif
            TX_I: begin
                // While a pop is landing on this edge the show-ahead head is stale: wait one cycle.
                if (!tx_rdreq_q) begin
                    if (FLAGB && !tx_empty && (tx_cnt_q < TX_MAX)) begin
                        state_d  = TX_Q;
                        fd_out_d = tx_iword;
                        slwr_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        fd_oe_d = 1'b0;
                    end
                end
            end
            TX_Q: begin
                state_d    = TX_I;
                fd_out_d   = tx_qword;
                slwr_d     = 1'b0;
                tx_rdreq_d = 1'b1;
                tx_cnt_d   = tx_cnt_q + TXC_W'(1);
            end
            RX_ADDR: begin
                state_d = RX_READ;
            end
            RX_READ: begin
                if (FLAGA && !rx_full && (rx_cnt_q < RX_MAX)) begin
                    slrd_d   = 1'b0;
                    rx_cnt_d = rx_cnt_q + RXC_W'(1);
                end else begin
                    state_d = RX_TURN;
                    sloe_d  = 1'b1;
                end
            end
            RX_TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge IFCLK) begin
        if (reset) begin
            state_q    <= IDLE;
            last_rx_q  <= 1'b1;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            fd_out_q   <= '0;
            fd_oe_q    <= 1'b0;
            slwr_q     <= 1'b1;
            slrd_q     <= 1'b1;
            sloe_q     <= 1'b1;
            fifo_adr_q <= 2'b10;
            tx_rdreq_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`ifdef FRAME_SYNC_EN
            seq_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_rx_q  <= last_rx_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            fd_out_q   <= fd_out_d;
            fd_oe_q    <= fd_oe_d;
            slwr_q     <= slwr_d;
            slrd_q     <= slrd_d;
            sloe_q     <= sloe_d;
            fifo_adr_q <= fifo_adr_d;
            tx_rdreq_q <= tx_rdreq_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
`ifdef FRAME_SYNC_EN
            seq_q      <= seq_d;
`endif
        end
    end

    assign tx_rdreq = tx_rdreq_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign FD_out   = fd_out_q;
    assign FD_oe    = fd_oe_q;
    assign SLWR     = slwr_q;
    assign SLRD     = slrd_q;
    assign SLOE     = sloe_q;
    assign FIFO_ADR = fifo_adr_q;

endmodule

// File: tb/tb_fx2_fifo_arbiter.sv
// Directed bench for fx2_fifo_arbiter: show-ahead I/Q source and EP2 word source modelled here,
// bus activity sampled 1 time unit after each IFCLK rising edge.
module tb_fx2_fifo_arbiter;

    logic        IFCLK = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] tx_iword, tx_qword, rx_data, FD_in, FD_out;
    logic        tx_empty, tx_rdreq, rx_valid, rx_full, FLAGA, FLAGB;
    logic        FD_oe, SLWR, SLRD, SLOE;
    logic [1:0]  FIFO_ADR;

    fx2_fifo_arbiter #(.TX_BURST(32), .RX_BURST(8)) dut (
        .IFCLK(IFCLK), .reset(reset),
        .tx_iword(tx_iword), .tx_qword(tx_qword), .tx_empty(tx_empty), .tx_rdreq(tx_rdreq),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
        .FLAGA(FLAGA), .FLAGB(FLAGB), .FD_in(FD_in), .FD_out(FD_out), .FD_oe(FD_oe),
        .SLWR(SLWR), .SLRD(SLRD), .SLOE(SLOE), .FIFO_ADR(FIFO_ADR)
    );

    always #5 IFCLK = ~IFCLK;

    // Source models: pair k is {I=0x1000+k, Q=0x2000+k}; EP2 word k is k+1 (k counted from the base).
    int tx_rd = 0, tx_avail = 0, tx_base = 0;
    int ep2_rd = 0, ep2_avail = 0, ep2_base = 0;
    bit flaga_en = 1'b0;
    bit flagb_r = 1'b0;
    bit rx_full_r = 1'b0;

    assign tx_iword = 16'h1000 + 16'(tx_rd - tx_base);
    assign tx_qword = 16'h2000 + 16'(tx_rd - tx_base);
    assign tx_empty = (tx_rd >= tx_avail);
    assign FD_in    = 16'(ep2_rd - ep2_base + 1);
    assign FLAGA    = flaga_en && (ep2_rd < ep2_avail);
    assign FLAGB    = flagb_r;
    assign rx_full  = rx_full_r;

    always @(posedge IFCLK) begin
        if (tx_rdreq && !tx_empty) tx_rd <= tx_rd + 1;
        if (!SLRD) ep2_rd <= ep2_rd + 1;
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] wr_q[$];
    logic [15:0] rx_q[$];
    int grants[$];
    int rdreq_n, slrd_n, conflict_n, oe_bad_n;
    logic prev_oe, prev_sloe;

    task automatic clear_mon();
        wr_q.delete(); rx_q.delete(); grants.delete();
        rdreq_n = 0; slrd_n = 0; conflict_n = 0; oe_bad_n = 0;
        prev_oe = FD_oe; prev_sloe = SLOE;
    endtask

    task automatic step();
        @(posedge IFCLK); #1;
        if (!SLWR) begin
            wr_q.push_back(FD_out);
            if (!FD_oe) oe_bad_n++;
        end
        if (tx_rdreq) rdreq_n++;
        if (!SLRD) slrd_n++;
        if (rx_valid) rx_q.push_back(rx_data);
        if (FD_oe && !SLOE) conflict_n++;
        if (FD_oe && !prev_oe) grants.push_back(1);
        if (!SLOE && prev_sloe) grants.push_back(2);
        prev_oe = FD_oe;
        prev_sloe = SLOE;
    endtask

    task automatic do_reset();
        flagb_r = 1'b0; flaga_en = 1'b0; rx_full_r = 1'b0;
        tx_avail = tx_rd; ep2_avail = ep2_rd;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        tx_base = tx_rd; ep2_base = ep2_rd;
        clear_mon();
    endtask

    task automatic test_reset();
        logic [7:0] ctl;
        do_reset();
        ctl = {SLWR, SLRD, SLOE, FIFO_ADR, FD_oe, tx_rdreq, rx_valid};
        checks++; if (ctl !== 8'b1111_0000) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 8'b1111_0000); end
        checks++; if (FD_out !== 16'h0000) begin errors++; $display("FAIL reset_fd_out: got %h expected 0000", FD_out); end
        checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
        // RX blocked by rx_full, TX blocked by empty source: no grant at all.
        ep2_avail = ep2_rd + 8; flaga_en = 1'b1; rx_full_r = 1'b1; flagb_r = 1'b1;
        for (int n = 0; n < 6; n++) step();
        checks++; if (grants.size() !== 0) begin errors++; $display("FAIL blocked_grants: got %0d expected 0", grants.size()); end
        checks++; if (slrd_n !== 0) begin errors++; $display("FAIL blocked_slrd: got %0d expected 0", slrd_n); end
        $display("test_reset: ctl=%b grants=%0d", ctl, grants.size());
    endtask

    task automatic test_tx_burst();
        logic [4:0] ctl;
        bit done = 0;
        int bad = 0;
        do_reset();
        tx_avail = tx_rd + 40; flagb_r = 1'b1;
        step();
        ctl = {FIFO_ADR, FD_oe, SLWR, SLOE};
        checks++; if (ctl !== 5'b10_1_1_1) begin errors++; $display("FAIL tx_addr_cycle: got %b expected 10111", ctl); end
        for (int n = 0; n < 400; n++) begin
            step();
            if (!FD_oe) begin done = 1; break; end
        end
        flagb_r = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL tx_burst_timeout: got no release expected release"); end
        checks++; if (wr_q.size() !== 64) begin errors++; $display("FAIL tx_burst_words: got %0d expected 64", wr_q.size()); end
        for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i] !== ((i % 2 == 0) ? 16'h1000 + 16'(i / 2) : 16'h2000 + 16'(i / 2))) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL tx_burst_data: got %0d bad words expected 0", bad); end
        checks++; if (rdreq_n !== 32) begin errors++; $display("FAIL tx_burst_rdreq: got %0d expected 32", rdreq_n); end
        checks++; if (oe_bad_n !== 0) begin errors++; $display("FAIL tx_burst_oe: got %0d writes without FD_oe expected 0", oe_bad_n); end
        for (int n = 0; n < 4; n++) step();
        checks++; if (wr_q.size() !== 64 || FD_oe !== 1'b0) begin errors++; $display("FAIL tx_burst_idle: got %0d words oe=%b expected 64 oe=0", wr_q.size(), FD_oe); end
        checks++; if (tx_rd - tx_base !== 32) begin errors++; $display("FAIL tx_burst_popped: got %0d expected 32", tx_rd - tx_base); end
        $display("test_tx_burst: %0d words, %0d pops", wr_q.size(), rdreq_n);
    endtask

    task automatic test_rx_burst();
        logic [4:0] ctl;
        bit done = 0;
        int bad = 0;
        do_reset();
        ep2_avail = ep2_rd + 8; flaga_en = 1'b1;
        step();
        ctl = {FIFO_ADR, FD_oe, SLOE, SLRD};
        checks++; if (ctl !== 5'b00_0_0_1) begin errors++; $display("FAIL rx_addr_cycle: got %b expected 00001", ctl); end
        for (int n = 0; n < 100; n++) begin
            step();
            if (SLOE) begin done = 1; break; end
        end
        checks++; if (!done) begin errors++; $display("FAIL rx_turn_timeout: got SLOE low expected SLOE high"); end
        checks++; if (SLRD !== 1'b1 || rx_valid !== 1'b1 || rx_data !== 16'h0008) begin errors++; $display("FAIL rx_turn_cycle: got slrd=%b valid=%b data=%h expected 1 1 0008", SLRD, rx_valid, rx_data); end
        step(); step();
        checks++; if (slrd_n !== 8) begin errors++; $display("FAIL rx_slrd_count: got %0d expected 8", slrd_n); end
        checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL rx_word_count: got %0d expected 8", rx_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 16'(i + 1)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rx_data_seq: got %0d bad words expected 0", bad); end
        $display("test_rx_burst: %0d reads, %0d words", slrd_n, rx_q.size());
    endtask

    task automatic test_round_robin();
        bit done = 0;
        int code, bad = 0;
        do_reset();
        tx_avail = tx_rd + 80; flagb_r = 1'b1;
        ep2_avail = ep2_rd + 40; flaga_en = 1'b1;
        for (int n = 0; n < 800; n++) begin
            step();
            if (grants.size() >= 4) begin done = 1; break; end
        end
        flagb_r = 1'b0; flaga_en = 1'b0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (!FD_oe && SLOE && SLRD) break;
        end
        checks++; if (!done) begin errors++; $display("FAIL rr_timeout: got %0d grants expected 4", grants.size()); end
        code = 0;
        for (int i = 0; i < 4 && i < grants.size(); i++) code = code * 10 + grants[i];
        checks++; if (code !== 1212) begin errors++; $display("FAIL rr_order: got %0d expected 1212 (1=TX 2=RX)", code); end
        checks++; if (conflict_n !== 0) begin errors++; $display("FAIL rr_oe_sloe: got %0d overlap cycles expected 0", conflict_n); end
        for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i] !== ((i % 2 == 0) ? 16'h1000 + 16'(i / 2) : 16'h2000 + 16'(i / 2))) bad++;
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 16'(i + 1)) bad++;
        checks++; if (bad !== 0 || wr_q.size() < 64) begin errors++; $display("FAIL rr_data: got %0d bad, %0d tx words expected 0 bad, >=64 words", bad, wr_q.size()); end
        $display("test_round_robin: grants=%0d tx_words=%0d rx_words=%0d", code, wr_q.size(), rx_q.size());
    endtask

    task automatic test_flagb_drop();
        bit done = 0;
        do_reset();
        tx_avail = tx_rd + 20; flagb_r = 1'b1;
        for (int n = 0; n < 200; n++) begin
            step();
            if (rdreq_n == 5) break;
        end
        flagb_r = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (!FD_oe) begin done = 1; break; end
        end
        for (int n = 0; n < 3; n++) step();
        checks++; if (!done) begin errors++; $display("FAIL flagb_release: got no release expected release"); end
        checks++; if (wr_q.size() !== 10) begin errors++; $display("FAIL flagb_words: got %0d expected 10", wr_q.size()); end
        checks++; if (rdreq_n !== 5 || tx_rd - tx_base !== 5) begin errors++; $display("FAIL flagb_pops: got %0d/%0d expected 5/5", rdreq_n, tx_rd - tx_base); end
        checks++; if (wr_q.size() == 0 || wr_q[wr_q.size() - 1] !== 16'h2004) begin errors++; $display("FAIL flagb_last_word: got %h expected 2004", (wr_q.size() == 0) ? 16'hxxxx : wr_q[wr_q.size() - 1]); end
        $display("test_flagb_drop: %0d words, %0d pops", wr_q.size(), rdreq_n);
    endtask

    task automatic test_reset_in_txq();
        logic [7:0] ctl;
        do_reset();
        tx_avail = tx_rd + 10; flagb_r = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (wr_q.size() >= 1) break;
        end
        checks++; if (FD_out !== 16'h1000 || SLWR !== 1'b0) begin errors++; $display("FAIL txq_entry: got %h slwr=%b expected 1000 slwr=0", FD_out, SLWR); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        ctl = {SLWR, SLRD, SLOE, FIFO_ADR, FD_oe, tx_rdreq, rx_valid};
        checks++; if (ctl !== 8'b1111_0000) begin errors++; $display("FAIL txq_reset_ctl: got %b expected 11110000", ctl); end
        checks++; if (FD_out !== 16'h0000) begin errors++; $display("FAIL txq_reset_fd: got %h expected 0000", FD_out); end
        checks++; if (rdreq_n !== 0 || tx_rd !== tx_base) begin errors++; $display("FAIL txq_no_pop: got %0d pulses %0d pops expected 0 0", rdreq_n, tx_rd - tx_base); end
        wr_q.delete();
        for (int n = 0; n < 30; n++) begin
            step();
            if (wr_q.size() >= 2) break;
        end
        flagb_r = 1'b0;
        checks++; if (wr_q.size() < 2 || wr_q[0] !== 16'h1000 || wr_q[1] !== 16'h2000) begin errors++; $display("FAIL txq_resend: got %0d words first %h expected 1000 2000", wr_q.size(), (wr_q.size() == 0) ? 16'hxxxx : wr_q[0]); end
        $display("test_reset_in_txq: resent %0d words", wr_q.size());
    endtask

    task automatic run_one_grant(output bit ok);
        bit seen = 0;
        ok = 0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (FD_oe) seen = 1;
            if (seen && !FD_oe) begin ok = 1; break; end
        end
    endtask

    task automatic test_frame_header();
        bit ok1, ok2;
        logic [15:0] a0, a1, b0, b1;
        logic [15:0] e0, e1, f0, f1;
        int n1;
`ifdef FRAME_SYNC_EN
        e0 = 16'h7F7F; e1 = 16'h0000; f0 = 16'h7F7F; f1 = 16'h0001;
`else
        e0 = 16'h1000; e1 = 16'h2000; f0 = 16'h1001; f1 = 16'h2001;
`endif
        do_reset();
        tx_avail = tx_rd + 1; flagb_r = 1'b1;
        run_one_grant(ok1);
        n1 = wr_q.size();
        a0 = (n1 > 0) ? wr_q[0] : 16'hxxxx;
        a1 = (n1 > 1) ? wr_q[1] : 16'hxxxx;
        wr_q.delete();
        tx_avail = tx_rd + 1;
        run_one_grant(ok2);
        b0 = (wr_q.size() > 0) ? wr_q[0] : 16'hxxxx;
        b1 = (wr_q.size() > 1) ? wr_q[1] : 16'hxxxx;
        flagb_r = 1'b0;
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL frame_timeout: got %b%b expected 11", ok1, ok2); end
        checks++; if (a0 !== e0 || a1 !== e1) begin errors++; $display("FAIL frame_first: got %h %h expected %h %h", a0, a1, e0, e1); end
        checks++; if (b0 !== f0 || b1 !== f1) begin errors++; $display("FAIL frame_second: got %h %h expected %h %h", b0, b1, f0, f1); end
`ifdef FRAME_SYNC_EN
        checks++; if (n1 !== 4) begin errors++; $display("FAIL frame_len: got %0d expected 4", n1); end
`else
        checks++; if (n1 !== 2) begin errors++; $display("FAIL frame_len: got %0d expected 2", n1); end
`endif
        $display("test_frame_header: grant1 %h %h, grant2 %h %h", a0, a1, b0, b1);
    endtask

    initial begin
        test_reset();
        test_tx_burst();
        test_rx_burst();
        test_round_robin();
        test_flagb_drop();
        test_reset_in_txq();
        test_frame_header();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
